// File: rtl/wps_read_src_arbiter.sv
// N-way read-source arbiter: one session at a time, with queued start requests, a registered
// output FIFO that absorbs source read latency, a per-session beat counter and sticky error flags.
module wps_read_src_arbiter #(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned SEL_W      = 1,
  parameter int unsigned DATA_W     = 288,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_start_in,
  input  logic [NUM_SRC-1:0]          src_done_in,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data_in,
  input  logic [NUM_SRC-1:0]          src_valid_in,
  output logic [NUM_SRC-1:0]          src_ready_out,
  output logic [DATA_W-1:0]           tx_data_out,
  output logic                        tx_valid_out,
  input  logic                        rx_ready_in,
  output logic [SEL_W-1:0]            tx_src_out,
  output logic                        busy_out,
  output logic [31:0]                 beat_cnt_out,
  output logic                        err_stray_out,
  output logic                        err_ovf_out
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StActive = 2'd1;
  localparam logic [1:0] StDrain  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [31:0]        beat_cnt_q, beat_cnt_d;
  logic               err_stray_q, err_ovf_q;

  logic [DATA_W-1:0]  fifo_data [FIFO_DEPTH];
  logic [SEL_W-1:0]   fifo_src  [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  logic [NUM_SRC-1:0] sel_oh, cancel, pend_upd;
  logic [CNT_W-1:0]   free_cnt;
  logic               active, fifo_full, fifo_empty, room;
  logic               beat_in, push, pop, stray;
  logic [DATA_W-1:0]  sel_data;

  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (v[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  assign sel_oh     = NUM_SRC'(1) << sel_q;
  assign active     = (state_q == StActive);
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign free_cnt   = CNT_W'(FIFO_DEPTH) - count_q;
  // Keep READ_LAT entries spare so beats still in flight after ready drops have somewhere to go.
  assign room       = (free_cnt > CNT_W'(READ_LAT));

  // Beats are taken on valid alone; ready only throttles new requests.
  assign beat_in = active && |(src_valid_in & sel_oh);
  assign push    = beat_in && !fifo_full;
  assign pop     = !fifo_empty && rx_ready_in;
  assign stray   = (state_q != StIdle) && |(src_valid_in & ~sel_oh);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (SEL_W'(k) == sel_q) sel_data = src_data_in[k*DATA_W +: DATA_W];
    end
  end

  // A done from the selected source never cancels its own restart request.
  assign cancel   = src_done_in & ~sel_oh;
  assign pend_upd = (pending_q | src_start_in) & ~cancel;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    pending_d  = pending_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|src_start_in) begin
          sel_d      = lowest(src_start_in);
          pending_d  = src_start_in & ~(NUM_SRC'(1) << lowest(src_start_in));
          beat_cnt_d = '0;
          state_d    = StActive;
        end
      end
      StActive: begin
        pending_d = pend_upd;
        if (push && (beat_cnt_q != '1)) beat_cnt_d = beat_cnt_q + 32'd1;
        if (|(src_done_in & sel_oh)) state_d = StDrain;
      end
      StDrain: begin
        pending_d = pend_upd;
        if (fifo_empty) begin
          if (|pend_upd) begin
            sel_d      = lowest(pend_upd);
            pending_d  = pend_upd & ~(NUM_SRC'(1) << lowest(pend_upd));
            beat_cnt_d = '0;
            state_d    = StActive;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      pending_q   <= '0;
      beat_cnt_q  <= '0;
      err_stray_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      pending_q  <= pending_d;
      beat_cnt_q <= beat_cnt_d;
      if (stray) err_stray_q <= 1'b1;
      if (beat_in && fifo_full) err_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= sel_data;
      fifo_src[wr_ptr_q]  <= sel_q;
    end
  end

  assign src_ready_out = (active && room) ? sel_oh : '0;
  assign tx_valid_out  = !fifo_empty;
  // Storage is not reset, so gate the head entry to keep outputs at zero when empty.
  assign tx_data_out   = tx_valid_out ? fifo_data[rd_ptr_q] : '0;
  assign tx_src_out    = tx_valid_out ? fifo_src[rd_ptr_q] : '0;
  assign busy_out      = (state_q != StIdle) || tx_valid_out;
  assign beat_cnt_out  = beat_cnt_q;
  assign err_stray_out = err_stray_q;
  assign err_ovf_out   = err_ovf_q;

endmodule

// File: tb/tb_wps_read_src_arbiter.sv
// Bench for wps_read_src_arbiter: session table plus hand-written corner sequences, with a
// scoreboard queue checked against every beat that leaves on the tx stream.
module tb_wps_read_src_arbiter;

  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned SEL_W      = 1;
  localparam int unsigned DATA_W     = 288;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned READ_LAT   = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        src_start_in;
  logic [NUM_SRC-1:0]        src_done_in;
  logic [NUM_SRC*DATA_W-1:0] src_data_in;
  logic [NUM_SRC-1:0]        src_valid_in;
  logic [NUM_SRC-1:0]        src_ready_out;
  logic [DATA_W-1:0]         tx_data_out;
  logic                      tx_valid_out;
  logic                      rx_ready_in;
  logic [SEL_W-1:0]          tx_src_out;
  logic                      busy_out;
  logic [31:0]               beat_cnt_out;
  logic                      err_stray_out;
  logic                      err_ovf_out;

  wps_read_src_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .SEL_W     (SEL_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .READ_LAT  (READ_LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_start_in (src_start_in),
    .src_done_in  (src_done_in),
    .src_data_in  (src_data_in),
    .src_valid_in (src_valid_in),
    .src_ready_out(src_ready_out),
    .tx_data_out  (tx_data_out),
    .tx_valid_out (tx_valid_out),
    .rx_ready_in  (rx_ready_in),
    .tx_src_out   (tx_src_out),
    .busy_out     (busy_out),
    .beat_cnt_out (beat_cnt_out),
    .err_stray_out(err_stray_out),
    .err_ovf_out  (err_ovf_out)
  );

  typedef struct {
    logic [SEL_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    int          src;
    int          nbeats;
    logic [31:0] exp_cnt;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: compare each beat that completes a tx handshake.
  always @(negedge clk) begin
    if (!rst && tx_valid_out && rx_ready_in) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_beat: got src %0d data %0h required no beat", tx_src_out,
                 tx_data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (tx_data_out !== e.data || tx_src_out !== e.src) begin
          n_fail++;
          $display("FAIL tx_beat: got src %0d data %0h required src %0d data %0h", tx_src_out,
                   tx_data_out, e.src, e.data);
        end
      end
      last_pop_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int src, input int idx);
    logic [DATA_W-1:0] d;
    for (int w = 0; w < int'(DATA_W / 32); w++) d[w*32 +: 32] = $urandom;
    d[7:0]  = 8'(idx);
    d[15:8] = 8'(src);
    return d;
  endfunction

  task automatic present(input int src, input int idx, input bit expect_store);
    exp_t e;
    e.src  = SEL_W'(src);
    e.data = mk_data(src, idx);
    src_valid_in[src] = 1'b1;
    src_data_in[src*DATA_W +: DATA_W] = e.data;
    if (expect_store) sb.push_back(e);
  endtask

  task automatic pulse_start(input logic [NUM_SRC-1:0] m);
    src_start_in = m;
    tick();
    src_start_in = '0;
  endtask

  task automatic pulse_done(input logic [NUM_SRC-1:0] m);
    src_done_in = m;
    tick();
    src_done_in = '0;
  endtask

  // Source model: presents a beat only while its ready is high.
  task automatic drive_beats(input int src, input int n);
    int sent = 0;
    int guard = 0;
    while (sent < n && guard < 200) begin
      if (src_ready_out[src]) begin
        present(src, sent, 1'b1);
        sent++;
      end else begin
        src_valid_in[src] = 1'b0;
      end
      tick();
      guard++;
    end
    src_valid_in[src] = 1'b0;
    if (sent < n) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drive_timeout: got %0d beats sent required %0d", sent, n);
    end
  endtask

  task automatic wait_idle(output int lat);
    int guard = 0;
    while (busy_out && guard < 200) begin
      tick();
      guard++;
    end
    check("idle_reached", busy_out, 1'b0);
    lat = cyc - last_pop_cyc;
  endtask

  vec_t vecs[4];
  int   lat;
  int   g;
  logic exp_rdy[4];

  initial begin
    vecs[0] = '{src: 1, nbeats: 8, exp_cnt: 32'd8, exp_lat: 2};
    vecs[1] = '{src: 0, nbeats: 3, exp_cnt: 32'd3, exp_lat: 2};
    vecs[2] = '{src: 1, nbeats: 1, exp_cnt: 32'd1, exp_lat: 2};
    vecs[3] = '{src: 0, nbeats: 5, exp_cnt: 32'd5, exp_lat: 2};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1;
    src_start_in = '0;
    src_done_in = '0;
    src_data_in = '0;
    src_valid_in = '0;
    rx_ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid_out, 1'b0);
    check("rst_tx_data", tx_data_out[63:0], 64'd0);
    check("rst_ready", src_ready_out, 2'b00);
    check("rst_busy", busy_out, 1'b0);
    check("rst_beat_cnt", beat_cnt_out, 32'd0);
    check("rst_errs", {err_stray_out, err_ovf_out}, 2'b00);
    rst = 1'b0;
    tick();

    // Single sessions, free-flowing sink.
    for (int i = 0; i < 4; i++) begin
      pulse_start(NUM_SRC'(1) << vecs[i].src);
      check("first_ready", src_ready_out, 64'(NUM_SRC'(1) << vecs[i].src));
      drive_beats(vecs[i].src, vecs[i].nbeats);
      pulse_done(NUM_SRC'(1) << vecs[i].src);
      wait_idle(lat);
      check("sess_beat_cnt", beat_cnt_out, vecs[i].exp_cnt);
      check("sess_idle_lat", 64'(lat), 64'(vecs[i].exp_lat));
      check("sess_sb_empty", 64'(sb.size()), 64'd0);
      check("sess_errs", {err_stray_out, err_ovf_out}, 2'b00);
    end

    // Simultaneous start: lowest index first, the other queued.
    pulse_start(2'b11);
    check("sim_first_ready", src_ready_out, 2'b01);
    drive_beats(0, 4);
    check("sim_cnt0", beat_cnt_out, 32'd4);
    pulse_done(2'b01);
    g = 0;
    while (!src_ready_out[1] && g < 50) begin
      tick();
      g++;
    end
    check("sim_switch_ready", src_ready_out, 2'b10);
    check("sim_switch_cnt", beat_cnt_out, 32'd0);
    drive_beats(1, 4);
    pulse_done(2'b10);
    wait_idle(lat);
    check("sim_cnt1", beat_cnt_out, 32'd4);
    check("sim_errs", {err_stray_out, err_ovf_out}, 2'b00);
    check("sim_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: source keeps valid for READ_LAT cycles after ready drops.
    rx_ready_in = 1'b0;
    pulse_start(2'b01);
    for (int i = 0; i < 4; i++) begin
      check("bp_ready", src_ready_out[0], exp_rdy[i]);
      present(0, i, 1'b1);
      tick();
    end
    src_valid_in[0] = 1'b0;
    check("bp_tx_valid", tx_valid_out, 1'b1);
    check("bp_ovf", err_ovf_out, 1'b0);
    check("bp_cnt", beat_cnt_out, 32'd4);
    check("bp_hold_data", tx_data_out[63:0], sb[0].data[63:0]);
    // One more late beat while full: dropped.
    present(0, 9, 1'b0);
    tick();
    src_valid_in[0] = 1'b0;
    check("ovf_flag", err_ovf_out, 1'b1);
    check("ovf_cnt", beat_cnt_out, 32'd4);
    tick();
    check("ovf_sticky", err_ovf_out, 1'b1);
    check("ovf_hold_data", tx_data_out[63:0], sb[0].data[63:0]);
    rx_ready_in = 1'b1;
    pulse_done(2'b01);
    wait_idle(lat);
    check("ovf_sb_empty", 64'(sb.size()), 64'd0);
    check("ovf_sticky_end", err_ovf_out, 1'b1);

    // Stray valid and cancelled request.
    pulse_start(2'b01);
    present(1, 0, 1'b0);
    tick();
    src_valid_in[1] = 1'b0;
    check("stray_flag", err_stray_out, 1'b1);
    pulse_start(2'b10);
    pulse_done(2'b10);
    drive_beats(0, 2);
    pulse_done(2'b01);
    wait_idle(lat);
    check("cancel_cnt", beat_cnt_out, 32'd2);
    repeat (3) tick();
    check("cancel_busy", busy_out, 1'b0);
    check("cancel_ready", src_ready_out, 2'b00);
    check("stray_sticky", err_stray_out, 1'b1);

    // Async reset with three beats stored.
    rx_ready_in = 1'b0;
    pulse_start(2'b10);
    for (int i = 0; i < 3; i++) begin
      present(1, i, 1'b1);
      tick();
    end
    src_valid_in[1] = 1'b0;
    check("pre_rst_valid", tx_valid_out, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_tx_valid", tx_valid_out, 1'b0);
    check("arst_ready", src_ready_out, 2'b00);
    check("arst_busy", busy_out, 1'b0);
    sb.delete();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy_out, 1'b0);
    check("post_rst_cnt", beat_cnt_out, 32'd0);
    check("post_rst_errs", {err_stray_out, err_ovf_out}, 2'b00);
    rx_ready_in = 1'b1;
    pulse_start(2'b01);
    check("post_rst_ready", src_ready_out, 2'b01);
    drive_beats(0, 2);
    pulse_done(2'b01);
    wait_idle(lat);
    check("post_rst_sess_cnt", beat_cnt_out, 32'd2);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wps_read_src_arbiter.md
Name: wps_read_src_arbiter

Overview:
- Parametrised successor to the 2-way DDR3/on-chip read-data mux in the wps top level.
- Arbitrates N read sources, each with its own start/done session pulses and valid/ready beat stream, into one registered stream for the 256-in/24-out width converter.
- Adds a latency-tolerant output FIFO, queued session requests, a per-session beat counter and sticky error flags.
- Single clock domain (memory clock).

Parameters:
- NUM_SRC, 2, number of read sources (2..8)
- SEL_W, 1, width of source index; NUM_SRC <= 2**SEL_W
- DATA_W, 288, beat width (256 data + 32 sideband)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= READ_LAT+2)
- READ_LAT, 2, max cycles a source may still present valid after its ready drops

Ports:
- clk  input  1  memory-domain clock
- rst  input  1  asynchronous, active-high reset
- src_start_in  input  NUM_SRC  one-cycle pulse: source k begins a read session
- src_done_in  input  NUM_SRC  one-cycle pulse: source k has finished its session
- src_data_in  input  NUM_SRC*DATA_W  beat data; source k occupies bits [k*DATA_W +: DATA_W]
- src_valid_in  input  NUM_SRC  beat valid from source k
- src_ready_out  output  NUM_SRC  read request to source k
- tx_data_out  output  DATA_W  beat to width converter
- tx_valid_out  output  1  beat valid
- rx_ready_in  input  1  converter ready
- tx_src_out  output  SEL_W  index of source that produced the current tx beat
- busy_out  output  1  session active or FIFO not empty
- beat_cnt_out  output  32  beats accepted in current/last session
- err_stray_out  output  1  sticky: valid seen from a non-selected source
- err_ovf_out  output  1  sticky: beat arrived with FIFO full (beat dropped)

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; sel=0; pending=0; FIFO empty; counters and flags 0. Reset asserted mid-session drops all in-flight beats and pending requests. No state carries over.
- States:
  - IDLE: any src_start_in bit set → latch sel = lowest set index; remaining set bits go into pending; beat_cnt=0; go to ACTIVE next cycle.
  - ACTIVE: src_ready_out[sel] = (free FIFO entries > READ_LAT); all other ready bits 0. Beat accepted when src_valid_in[sel]=1 regardless of ready (covers read latency); beat_cnt += 1, saturating at 2^32-1. src_done_in[sel] → DRAIN.
  - DRAIN: ready all 0. Wait until FIFO empty and tx handshake complete. Then:
    - pending≠0 → sel = lowest pending index, clear that bit, beat_cnt=0, go to ACTIVE.
    - pending=0 → IDLE.
- Start pulses arriving in ACTIVE/DRAIN set pending[k].
  - A start for the selected source in ACTIVE sets pending (restart after drain).
  - Start and done for the same selected source in the same ACTIVE cycle: done is taken, pending set.
- src_done_in for a non-selected source clears its pending bit (cancel). Done in IDLE is ignored.
- src_valid_in for a non-selected source: beat discarded, err_stray_out set.
- FIFO full at an accepted beat: beat dropped, beat_cnt not incremented, err_ovf_out set.
- Flags clear only on reset.
- Latency: a beat accepted in cycle t appears on tx_data_out/tx_valid_out at t+1 if the FIFO was empty. tx_src_out travels with each entry.
- tx handshake: beat leaves on tx_valid_out & rx_ready_in. tx_data_out/tx_src_out held stable while tx_valid_out=1 and rx_ready_in=0. Simultaneous push and pop on a full FIFO is not allowed, because ready already guarantees READ_LAT headroom.
- busy_out = (state≠IDLE) | tx_valid_out.
- Start→first ready: start at cycle t, src_ready_out[sel]=1 at t+1.

Test Plan:
- Single session: start[1] pulse, source 1 streams 8 beats with rx_ready_in=1, then done → tx_src_out=1 on all 8 beats; beat_cnt_out=8; IDLE, busy_out=0 two cycles after last tx pop.
- Simultaneous start: start=2'b11 in the same cycle, each source sends 4 beats → all 4 source-0 beats leave before any source-1 beat; beat_cnt resets to 0 at the switch; no errors.
- Backpressure/latency: FIFO_DEPTH=4, READ_LAT=2, rx_ready_in=0, source keeps valid 2 cycles after ready drops → ready falls once occupancy reaches 2; 4 beats stored; err_ovf_out=0. Releasing rx_ready_in delivers all 4 in order.
- Overflow: force a 3rd late beat with the FIFO full → beat dropped, err_ovf_out=1 and stays 1; beat_cnt unchanged.
- Stray/cancel: during a source-0 session, source 1 asserts valid → err_stray_out=1, no source-1 beat on tx. Start[1] then done[1] before drain → source 1 is never selected.
- Async reset mid-session: assert rst with 3 beats in the FIFO → tx_valid_out=0 and all ready bits 0 immediately; after release, state is IDLE with counters and flags at 0.
